// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix column scanner with scan-based debounce,
// ghost rejection and a valid/ready key output with sticky overflow.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DLAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0] DMAX = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  state_t state;

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [DW-1:0] dcnt;
  logic [1:0]    cidx;
  logic [15:0]   snap;
  logic [15:0]   full;
  logic [3:0]    cnt;
  logic [3:0]    kreg;
  logic [3:0]    cand;
  logic [4:0]    ones;
  logic [4:0]    nxt;
  logic          last;
  logic          eos;
  logic          found;
  logic          reach;
  logic          accept;
  logic          xfer;

  assign last  = dcnt == DLAST;
  assign eos   = last && (cidx == 2'd3);
  assign xfer  = key_valid && key_ready;
  assign found = ones == 5'd1;
  assign nxt   = {1'b0, cnt} + 5'd1;
  assign reach = nxt >= {1'b0, DMAX};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= row;
      sync2 <= sync1;
    end
  end

  // The live column slice is patched in so the col 3 sample joins this scan
  always_comb begin
    full = snap;
    full[{cidx, 2'b00} +: 4] = ~sync2;
    ones = '0;
    cand = '0;
    for (int i = 0; i < 16; i++) begin
      ones = ones + 5'(full[i]);
      if (full[i]) cand = 4'(i);
    end
  end

  always_comb begin
    accept = 1'b0;
    if (eos && state == DEBOUNCE && found && cand == kreg && reach)
      accept = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dcnt <= '0;
      cidx <= '0;
      col  <= 4'b1110;
      snap <= '0;
    end else begin
      dcnt <= last ? '0 : dcnt + DW'(1);
      if (last) begin
        cidx <= cidx + 2'd1;
        col  <= {col[2:0], col[3]};
        snap[{cidx, 2'b00} +: 4] <= ~sync2;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      kreg     <= '0;
      key_held <= 1'b0;
    end else if (eos) begin
      unique case (state)
        IDLE: begin
          if (found) begin
            cnt   <= 4'd1;
            kreg  <= cand;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!found) begin
            state <= IDLE;
          end else if (cand != kreg) begin
            kreg <= cand;
            cnt  <= 4'd1;
          end else if (reach) begin
            cnt      <= DMAX;
            state    <= PRESSED;
            key_held <= 1'b1;
          end else begin
            cnt <= nxt[3:0];
          end
        end
        PRESSED: begin
          if (!found) begin
            cnt   <= 4'd1;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (found) begin
            state <= PRESSED;
          end else if (reach) begin
            cnt      <= DMAX;
            state    <= IDLE;
            key_held <= 1'b0;
          end else begin
            cnt <= nxt[3:0];
          end
        end
      endcase
    end
  end

  // A transfer on the accept edge frees the slot for the new key
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      if (!key_valid || xfer) begin
        key_code  <= kreg;
        key_valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (xfer) begin
      key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed + random scans of a modelled 4x4 keypad,
// checked against a run-length debounce model of the scanner.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DS = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        key_ready = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        overflow;
  logic [15:0] keys = '0;

  int n_cmp = 0;
  int n_bad = 0;

  bit         m_valid;
  bit         m_held;
  bit         m_ovf;
  logic [3:0] m_code;
  int         m_last;
  int         m_run;

  keypad_scanner #(
    .SCAN_DIV(SD),
    .DEBOUNCE_SCANS(DS)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .row(row),
    .col(col),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_held(key_held),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  // Physical keypad: a pressed key shorts its row to the driven-low column
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      if (col[c] === 1'b0)
        for (int r = 0; r < 4; r++)
          if (keys[c*4+r]) row[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cand_of(input logic [15:0] p);
    int n;
    int idx;
    n = 0;
    idx = -1;
    for (int i = 0; i < 16; i++)
      if (p[i]) begin
        n++;
        idx = i;
      end
    return (n == 1) ? idx : -1;
  endfunction

  function automatic logic [15:0] kb(input int k);
    logic [15:0] one;
    one = 16'd1;
    return one << k;
  endfunction

  task automatic m_reset();
    m_valid = 0;
    m_held  = 0;
    m_ovf   = 0;
    m_code  = '0;
    m_last  = -1;
    m_run   = 0;
  endtask

  task automatic m_eos(input int c, input bit rdy);
    bit acc;
    acc = 0;
    if (c == m_last) m_run++;
    else begin
      m_last = c;
      m_run  = 1;
    end
    if (!m_held && c >= 0 && m_run == DS) begin
      acc = 1;
      m_held = 1;
    end else if (m_held && c < 0 && m_run == DS) begin
      m_held = 0;
    end
    if (acc) begin
      if (!m_valid || rdy) begin
        m_code  = 4'(c);
        m_valid = 1;
      end else begin
        m_ovf = 1;
      end
    end else if (rdy && m_valid) begin
      m_valid = 0;
    end
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_col", 16'(col), 16'h000E);
    chk("rst_code", 16'(key_code), 16'h0);
    chk("rst_valid", 16'(key_valid), 16'h0);
    chk("rst_held", 16'(key_held), 16'h0);
    chk("rst_ovf", 16'(overflow), 16'h0);
    m_reset();
    keys = '0;
    key_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // One full scan with a fixed keypad; mode 1 = ready mid-scan, 2 = at scan end
  task automatic scan(input logic [15:0] p, input int mode);
    logic [3:0] ec;
    keys = p;
    for (int e = 1; e <= 16; e++) begin
      key_ready = (mode == 1 && e == 8) || (mode == 2 && e == 16);
      @(negedge clock);
      if (e % 4 == 0) begin
        ec = ~(4'b0001 << ((e / 4) % 4));
        chk("col", 16'(col), 16'(ec));
      end
      if (mode == 1 && e == 8) begin
        m_valid = 0;
        chk("xfer_valid", 16'(key_valid), 16'(m_valid));
      end
    end
    key_ready = 1'b0;
    m_eos(cand_of(p), mode == 2);
    chk("valid", 16'(key_valid), 16'(m_valid));
    chk("code", 16'(key_code), 16'(m_code));
    chk("held", 16'(key_held), 16'(m_held));
    chk("ovf", 16'(overflow), 16'(m_ovf));
  endtask

  function automatic logic [15:0] rnd_pat(input logic [15:0] prev);
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return prev;
    if (r < 7) return '0;
    if (r < 9) return kb($urandom_range(0, 15));
    return kb($urandom_range(0, 15)) | kb($urandom_range(0, 15));
  endfunction

  initial begin
    int lat;
    int r;
    logic [15:0] pat;

    do_reset();

    // Unaligned press of key 6: bounded latency
    repeat ($urandom_range(0, 15)) @(negedge clock);
    keys = kb(6);
    lat = 0;
    while (!key_valid && lat < 60) begin
      @(negedge clock);
      lat++;
    end
    chk("latency_ok", 16'(lat <= 51), 16'd1);
    chk("lat_code", 16'(key_code), 16'd6);
    repeat (20) @(negedge clock);
    chk("lat_hold_valid", 16'(key_valid), 16'd1);
    do_reset();

    // Key 6 accept, one transfer, no repeat while held
    scan(kb(6), 0);
    scan(kb(6), 0);
    chk("k6_valid", 16'(key_valid), 16'd1);
    chk("k6_code", 16'(key_code), 16'd6);
    scan(kb(6), 1);
    repeat (3) scan(kb(6), 0);
    chk("k6_norepeat", 16'(key_valid), 16'd0);
    chk("k6_held", 16'(key_held), 16'd1);
    repeat (2) scan('0, 0);
    chk("k6_released", 16'(key_held), 16'd0);

    // Ghost pair rejected
    repeat (10) scan(kb(0) | kb(5), 0);
    chk("ghost_valid", 16'(key_valid), 16'd0);
    chk("ghost_held", 16'(key_held), 16'd0);

    // Bouncing key 9 then steady
    repeat (3) begin
      scan(kb(9), 0);
      scan('0, 0);
    end
    chk("bounce_none", 16'(key_valid), 16'd0);
    repeat (4) scan(kb(9), 0);
    chk("k9_valid", 16'(key_valid), 16'd1);
    chk("k9_code", 16'(key_code), 16'd9);
    chk("k9_once", 16'(overflow), 16'd0);
    repeat (2) scan('0, 0);

    // Accept and transfer on the same edge
    scan(kb(2), 0);
    scan(kb(2), 2);
    chk("same_edge_code", 16'(key_code), 16'd2);
    chk("same_edge_valid", 16'(key_valid), 16'd1);
    chk("same_edge_ovf", 16'(overflow), 16'd0);
    repeat (2) scan('0, 0);
    scan('0, 1);

    // Overflow: key 3 pending when key 12 is accepted
    repeat (2) scan(kb(3), 0);
    repeat (2) scan('0, 0);
    repeat (2) scan(kb(12), 0);
    chk("ovf_code", 16'(key_code), 16'd3);
    chk("ovf_set", 16'(overflow), 16'd1);
    repeat (2) scan('0, 1);
    chk("ovf_sticky", 16'(overflow), 16'd1);

    do_reset();

    // Random keypad activity against the model
    pat = '0;
    for (int s = 0; s < 80; s++) begin
      pat = rnd_pat(pat);
      r = $urandom_range(0, 3);
      scan(pat, (r == 3) ? 2 : (r == 2) ? 1 : 0);
    end

    // Reset mid-debounce, then fresh scans
    scan('0, 1);
    repeat (2) scan('0, 0);
    scan(kb(7), 0);
    keys = kb(7);
    repeat (5) @(negedge clock);
    do_reset();
    scan(kb(7), 0);
    chk("post_rst_one_scan", 16'(key_valid), 16'd0);
    scan(kb(7), 0);
    chk("post_rst_valid", 16'(key_valid), 16'd1);
    chk("post_rst_code", 16'(key_code), 16'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
